// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: enable, settle, count synchronized roout rising edges over win_len clks, pulse done.
// Build option RO_FCNT_SAT_EN: saturate the count instead of wrapping it.
module ro_freq_counter #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SETTLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             roout,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TW    = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   hit;
  logic [WIN_W-1:0]       win_q;
  logic [TW-1:0]          timer;

  // Free-running synchronizer; prev holds the last synchronized sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], roout};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign hit = sync[SYNC_STAGES-1] & ~prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ro_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
      win_q <= '0;
      timer <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            ovf   <= 1'b0;
            win_q <= win_len;
            if (win_len != '0) begin
              timer <= SETTLE_LD;
              ro_en <= 1'b1;
              busy  <= 1'b1;
              state <= SETTLE;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        SETTLE: begin
          if (timer == '0) begin
            timer <= TW'(win_q) - TW'(1);
            state <= COUNT;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        COUNT: begin
          if (hit) begin
`ifdef RO_FCNT_SAT_EN
            if (count == '1) ovf <= 1'b1;
            else             count <= count + CNT_W'(1);
`else
            count <= count + CNT_W'(1);
            if (count == '1) ovf <= 1'b1;
`endif
          end
          if (timer == '0) begin
            ro_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DONE: begin
          // start is deliberately not sampled here
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Scoreboard bench: roout plays from a pre-built table, so expected edge counts are known when each start is issued.
module tb_ro_freq_counter;

  localparam int S    = 8;
  localparam int SYNC = 2;
  localparam int MAXC = 20000;

  typedef struct {
    int dc;
    int c16;
    bit o16;
    int c4;
    bit o4;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, roout = 1'b0;
  logic [15:0] win_len = '0;
  logic        ro_en, busy, done, ovf;
  logic [15:0] count;
  logic        ro_en4, busy4, done4, ovf4;
  logic [3:0]  count4;

  bit   rtab[MAXC];
  int   cyc = 0;
  int   checks = 0, failures = 0;
  int   act_lo = 0, act_hi = -1;
  int   held16 = 0, held4 = 0;
  bit   hov16 = 0, hov4 = 0;
  bit   mon_en = 0;
  exp_t sb[$];

  ro_freq_counter dut (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .roout(roout),
    .ro_en(ro_en), .busy(busy), .done(done), .count(count), .ovf(ovf)
  );

  ro_freq_counter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .roout(roout),
    .ro_en(ro_en4), .busy(busy4), .done(done4), .count(count4), .ovf(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n edges reported through a w-bit counter
  function automatic void fold(input int n, input int w, output int c, output bit o);
    int mx;
    mx = (1 << w) - 1;
`ifdef RO_FCNT_SAT_EN
    c = (n > mx) ? mx : n;
`else
    c = n % (1 << w);
`endif
    o = (n > mx);
  endfunction

  task automatic square(input int from, input int to);
    for (int c = from; c <= to; c++) rtab[c] = ((c - from) % 4) < 2;
  endtask

  // mode 0: quiet, 1: random start/win_len noise while busy, 2: start pulses at +3 and +20 with win_len=5
  task automatic run_meas(input int w, input int mode);
    int   c0, dc, n;
    exp_t e;
    c0 = cyc;
    start = 1'b1;
    win_len = w[15:0];
    n = 0;
    if (w == 0) begin
      dc = c0 + 1;
    end else begin
      dc = c0 + S + w + 1;
      // an roout rise in cycle j reaches the edge detector in cycle j+SYNC
      for (int k = c0 + S + 1; k <= c0 + S + w; k++)
        if (rtab[k-SYNC] && !rtab[k-SYNC-1]) n++;
      act_lo = c0 + 1;
      act_hi = c0 + S + w;
    end
    e.dc = dc;
    fold(n, 16, e.c16, e.o16);
    fold(n, 4, e.c4, e.o4);
    sb.push_back(e);
    for (int c = c0 + 1; c <= dc + 1; c++) begin
      step();
      if (c <= dc) begin
        case (mode)
          1: begin start = 1'($urandom_range(0, 1)); win_len = 16'($urandom); end
          2: begin start = (c == c0 + 3) || (c == c0 + 20); win_len = 16'd5; end
          default: start = 1'b0;
        endcase
      end else begin
        start = 1'b0;
      end
    end
    chk("done_missing", sb.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    bit   act;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        act = (cyc >= act_lo) && (cyc <= act_hi);
        chk("ro_en", ro_en, act);
        chk("busy", busy, act);
        chk("ro_en4", ro_en4, act);
        chk("done4", done4, done);
        if (done === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done at cycle %0d: got done=1 expected 0", cyc);
          end else begin
            e = sb.pop_front();
            chk("done_cycle", cyc, e.dc);
            chk("count", count, e.c16);
            chk("ovf", ovf, e.o16);
            chk("count4", count4, e.c4);
            chk("ovf4", ovf4, e.o4);
            held16 = e.c16; hov16 = e.o16;
            held4  = e.c4;  hov4  = e.o4;
          end
        end else if (busy === 1'b0) begin
          chk("held_count", count, held16);
          chk("held_ovf", ovf, hov16);
          chk("held_count4", count4, held4);
          chk("held_ovf4", ovf4, hov4);
        end
      end
    end
  end

  initial begin : roout_drv
    forever begin
      @(posedge clk);
      #1;
      if (cyc < MAXC) roout = rtab[cyc];
    end
  end

  initial begin : stim
    int c0, w;
    for (int c = 0; c < MAXC; c++) rtab[c] = 1'($urandom_range(0, 1));

    repeat (3) step();
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_ro_en", ro_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    repeat (20) step();

    // period-4 square from ro_en rise, window 100
    c0 = cyc;
    square(c0 + 1, c0 + 120);
    run_meas(100, 0);
    chk("count_range", (count >= 16'd24) && (count <= 16'd26), 1);
    repeat (2) step();

    run_meas(0, 0);
    repeat (2) step();

    run_meas(50, 2);
    repeat (2) step();

    // about 20 edges: overflows the 4-bit instance
    c0 = cyc;
    square(c0 + 1, c0 + 100);
    run_meas(80, 0);
    repeat (2) step();

    run_meas(1, 1);
    step();

    // abort at cycle 30 of a 100-cycle window
    c0 = cyc;
    start = 1'b1;
    win_len = 16'd100;
    act_lo = c0 + 1;
    act_hi = c0 + S + 100;
    step();
    start = 1'b0;
    while (cyc < c0 + 30) step();
    rst = 1'b1;
    act_hi = cyc;
    held16 = 0; hov16 = 0; held4 = 0; hov4 = 0;
    step();
    rst = 1'b0;
    chk("abort_ro_en", ro_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count", count, 0);
    chk("abort_ovf", ovf, 0);
    repeat (3) step();
    run_meas(40, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0)      w = 0;
      else if ($urandom_range(0, 3) == 0) w = $urandom_range(1, 3);
      else                                w = $urandom_range(4, 150);
      run_meas(w, 1);
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
